// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: feed / accumulate / drain sequencer for an N x N
// output-stationary MAC array. Optional macro SYSTOLIC_TILE_ACCUM_EN adds keep_psum.
module systolic_tile_ctrl #(
   parameter int N      = 4,
   parameter int KW     = 8,
   parameter int RD_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [KW-1:0]        k_len,
`ifdef SYSTOLIC_TILE_ACCUM_EN
   input  logic                 keep_psum,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [N-1:0]         a_vld,
   output logic [N*KW-1:0]      a_idx,
   output logic [N-1:0]         b_vld,
   output logic [N*KW-1:0]      b_idx,
   output logic                 set_reg,
   output logic                 sel_mux,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_row
);

   localparam int CW = KW + 1;
   localparam int RW = $clog2(N);
   localparam logic [1:0]    LAT       = 2'(RD_LAT);
   localparam logic [CW-1:0] FEED_XTRA = CW'(2 * N - 3);
   localparam logic [CW-1:0] WAIT_LAST = CW'(RD_LAT - 1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);

   typedef enum logic [2:0] {IDLE, FEED, WAIT, DRAIN, FIN} state_t;

   state_t          state_q, state_d, post_wait;
   logic [CW-1:0]   c_q, c_d, feed_last;
   logic [RW-1:0]   d_q, d_d;
   logic [KW-1:0]   k_q, k_d;
   logic            keep_q, keep_d;
   logic [1:0]      acc_sr_q, acc_sr_d;
   logic [3:0]      acc_vec;

   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [N-1:0]    a_vld_q, b_vld_q, lane_vld_d;
   logic [N*KW-1:0] a_idx_q, b_idx_q, lane_idx_d;
   logic            set_acc_q, set_acc_d;
   logic            sel_mux_q, sel_mux_d;
   logic            out_valid_q, out_valid_d;
   logic [RW-1:0]   out_row_q, out_row_d;

   assign feed_last = CW'(k_q) + FEED_XTRA;

   // Tile sequencing: state, step counter, drain row counter, captured K.
   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      d_d       = d_q;
      k_d       = k_q;
      keep_d    = keep_q;
      post_wait = keep_q ? FIN : DRAIN;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (k_len != '0) begin
                  k_d     = k_len;
                  c_d     = '0;
                  state_d = FEED;
`ifdef SYSTOLIC_TILE_ACCUM_EN
                  keep_d  = keep_psum;
`else
                  keep_d  = 1'b0;
`endif
               end else begin
                  state_d = FIN;
               end
            end
         end
         FEED: begin
            if (c_q == feed_last) begin
               c_d     = '0;
               state_d = (RD_LAT == 0) ? post_wait : WAIT;
            end else begin
               c_d = c_q + CW'(1);
            end
         end
         WAIT: begin
            if (c_q == WAIT_LAST) begin
               c_d     = '0;
               state_d = post_wait;
            end else begin
               c_d = c_q + CW'(1);
            end
         end
         DRAIN: begin
            if (out_ready) begin
               d_d = d_q + RW'(1);
               if (d_q == ROW_LAST) state_d = FIN;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (state_d == DRAIN && state_q != DRAIN) d_d = '0;
   end

   // Next values of the registered outputs, derived from the next state.
   always_comb begin
      lane_vld_d = '0;
      lane_idx_d = '0;
      for (int i = 0; i < N; i++) begin
         if (state_d == FEED && c_d >= CW'(i) &&
             c_d < CW'(i) + CW'(k_d)) begin
            lane_vld_d[i]          = 1'b1;
            lane_idx_d[i*KW +: KW] = KW'(c_d - CW'(i));
         end
      end
      acc_sr_d    = {acc_sr_q[0], state_q == FEED};
      acc_vec     = {acc_sr_q, state_q == FEED, state_d == FEED};
      set_acc_d   = acc_vec[LAT];
      busy_d      = (state_d != IDLE);
      done_d      = (state_d == FIN);
      sel_mux_d   = (state_d == DRAIN);
      out_valid_d = (state_d == DRAIN);
      out_row_d   = (state_d == DRAIN) ? ROW_LAST - d_d : '0;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         c_q         <= '0;
         d_q         <= '0;
         k_q         <= '0;
         keep_q      <= 1'b0;
         acc_sr_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         a_vld_q     <= '0;
         a_idx_q     <= '0;
         b_vld_q     <= '0;
         b_idx_q     <= '0;
         set_acc_q   <= 1'b0;
         sel_mux_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         d_q         <= d_d;
         k_q         <= k_d;
         keep_q      <= keep_d;
         acc_sr_q    <= acc_sr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         a_vld_q     <= lane_vld_d;
         a_idx_q     <= lane_idx_d;
         b_vld_q     <= lane_vld_d;
         b_idx_q     <= lane_idx_d;
         set_acc_q   <= set_acc_d;
         sel_mux_q   <= sel_mux_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
      end
   end

   // Drain shift follows the handshake so a stalled row leaves the array untouched.
   assign set_reg   = set_acc_q | (out_valid_q & out_ready);
   assign busy      = busy_q;
   assign done      = done_q;
   assign a_vld     = a_vld_q;
   assign a_idx     = a_idx_q;
   assign b_vld     = b_vld_q;
   assign b_idx     = b_idx_q;
   assign sel_mux   = sel_mux_q;
   assign out_valid = out_valid_q;
   assign out_row   = out_row_q;

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// tb_systolic_tile_ctrl: timeline model of the tile schedule plus a PE array
// model driven by the controls, checked against a plain matmul.
module tb_systolic_tile_ctrl;

   localparam int N      = 4;
   localparam int KW     = 8;
   localparam int RD_LAT = 1;
   localparam int RW     = 2;
   localparam int KMAX   = 16;
   localparam int VW     = 5 + 2 * N + 2 * N * KW + RW;
`ifdef SYSTOLIC_TILE_ACCUM_EN
   localparam bit ACC_EN = 1'b1;
`else
   localparam bit ACC_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic out_ready = 1'b0;
   logic [KW-1:0] k_len = '0;
   bit tb_keep = 1'b0;
`ifdef SYSTOLIC_TILE_ACCUM_EN
   logic keep_psum;
   assign keep_psum = tb_keep;
`endif
   logic busy, done, set_reg, sel_mux, out_valid;
   logic [N-1:0] a_vld, b_vld;
   logic [N*KW-1:0] a_idx, b_idx;
   logic [RW-1:0] out_row;
   logic [VW-1:0] act_v;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   systolic_tile_ctrl #(.N(N), .KW(KW), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .k_len     (k_len),
`ifdef SYSTOLIC_TILE_ACCUM_EN
      .keep_psum (keep_psum),
`endif
      .busy      (busy),
      .done      (done),
      .a_vld     (a_vld),
      .a_idx     (a_idx),
      .b_vld     (b_vld),
      .b_idx     (b_idx),
      .set_reg   (set_reg),
      .sel_mux   (sel_mux),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row)
   );

   assign act_v = {busy, done, a_vld, a_idx, b_vld, b_idx,
                   set_reg, sel_mux, out_valid, out_row};

   // schedule model
   bit m_act, m_fin, m_keep;
   int m_t, m_k, m_acc;
   // data and array model
   int A[N][KMAX];
   int B[KMAX][N];
   int C[N][N];
   int pe_acc[N][N];
   int a_r[N][N];
   int b_r[N][N];
   int a_del[0:RD_LAT][N];
   int b_del[0:RD_LAT][N];
   bit obs_ov, obs_done;

   typedef struct {
      int k;
      int srow;
      int slen;
      int exp_first;
      int exp_done;
   } vec_t;
   vec_t vt[5];

   task automatic chk(input string nm, input logic [VW-1:0] a,
                      input logic [VW-1:0] e);
      n_tests++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s @%0t got %h want %h", nm, $time, a, e);
      end
   endtask

   task automatic chk_int(input string nm, input int a, input int e);
      n_tests++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s @%0t got %0d want %0d", nm, $time, a, e);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_fin = 0; m_keep = 0;
      m_t = 0; m_k = 0; m_acc = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            C[i][j] = 0; pe_acc[i][j] = 0;
            a_r[i][j] = 0; b_r[i][j] = 0;
         end
      for (int d = 0; d <= RD_LAT; d++)
         for (int i = 0; i < N; i++) begin
            a_del[d][i] = 0; b_del[d][i] = 0;
         end
   endtask

   // One clock: check at negedge+1, update array model, advance at posedge.
   task automatic tick();
      logic [N-1:0] e_av;
      logic [N*KW-1:0] e_ai;
      logic e_busy, e_done, e_set, e_sel, e_ov;
      logic [RW-1:0] e_row;
      int f, ix, ain, bin;
      bit drain;
      int na[N][N];
      int nb[N][N];
      e_av = '0; e_ai = '0; e_busy = 0; e_done = 0;
      e_set = 0; e_sel = 0; e_ov = 0; e_row = '0;
      f = m_k + 2 * N - 2;
      drain = 0;
      if (m_act) begin
         e_busy = 1;
         if (m_fin) e_done = 1;
         else begin
            for (int i = 0; i < N; i++)
               if (m_t - 1 >= i && m_t - 1 < i + m_k) begin
                  e_av[i] = 1;
                  e_ai[i*KW +: KW] = KW'(m_t - 1 - i);
               end
            if (m_t > RD_LAT && m_t <= f + RD_LAT) e_set = 1;
            if (m_t > f + RD_LAT) begin
               drain = 1; e_ov = 1; e_sel = 1;
               e_row = RW'(N - 1 - m_acc);
               e_set = out_ready;
            end
         end
      end
      #1;
      obs_ov = out_valid;
      obs_done = done;
      chk("cycle", act_v, {e_busy, e_done, e_av, e_ai, e_av, e_ai,
                          e_set, e_sel, e_ov, e_row});
      if (drain && out_ready)
         for (int j = 0; j < N; j++)
            chk_int("psum", pe_acc[N-1][j], C[N-1-m_acc][j]);
      for (int i = 0; i < N; i++) begin
         ix = int'(a_idx[i*KW +: KW]);
         a_del[0][i] = (a_vld[i] && ix < KMAX) ? A[i][ix] : 0;
         ix = int'(b_idx[i*KW +: KW]);
         b_del[0][i] = (b_vld[i] && ix < KMAX) ? B[ix][i] : 0;
      end
      if (set_reg && !sel_mux) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               ain = (j == 0) ? a_del[RD_LAT][i] : a_r[i][j-1];
               bin = (i == 0) ? b_del[RD_LAT][j] : b_r[i-1][j];
               pe_acc[i][j] += ain * bin;
               na[i][j] = ain;
               nb[i][j] = bin;
            end
         a_r = na;
         b_r = nb;
      end else if (set_reg && sel_mux) begin
         for (int i = N - 1; i > 0; i--) pe_acc[i] = pe_acc[i-1];
         for (int j = 0; j < N; j++) pe_acc[0][j] = 0;
      end
      for (int d = RD_LAT; d > 0; d--) begin
         a_del[d] = a_del[d-1];
         b_del[d] = b_del[d-1];
      end
      @(posedge clk);
      if (m_act) begin
         if (m_fin) m_act = 0;
         else begin
            if (drain && out_ready) begin
               m_acc++;
               if (m_acc == N) begin
                  m_fin = 1;
                  for (int i = 0; i < N; i++)
                     for (int j = 0; j < N; j++) C[i][j] = 0;
               end
            end
            if (m_keep && m_t == f + RD_LAT) m_fin = 1;
            m_t++;
         end
      end else if (start) begin
         m_act = 1; m_t = 1; m_acc = 0;
         m_k = int'(k_len);
         m_fin = (k_len == '0);
         m_keep = tb_keep && ACC_EN;
         for (int k = 0; k < KMAX; k++)
            for (int i = 0; i < N; i++) begin
               A[i][k] = int'($urandom_range(0, 15));
               B[k][i] = int'($urandom_range(0, 15));
            end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               for (int k = 0; k < m_k && k < KMAX; k++)
                  C[i][j] += A[i][k] * B[k][j];
      end
      @(negedge clk);
   endtask

   task automatic run_tile(input int k, input int srow, input int slen,
                           input bit kp, output int first, output int donec);
      int stalled;
      stalled = 0;
      first = -1;
      donec = -1;
      start = 1;
      k_len = KW'(k);
      tb_keep = kp;
      for (int cyc = 0; cyc < 300 && donec < 0; cyc++) begin
         out_ready = 1;
         if (m_act && !m_fin && m_t > m_k + 2 * N - 2 + RD_LAT &&
             m_acc == srow && stalled < slen) begin
            out_ready = 0;
            stalled++;
         end
         tick();
         start = 0;
         if (obs_ov && first < 0) first = cyc;
         if (obs_done) donec = cyc;
      end
      out_ready = 1;
   endtask

   initial begin
      int first, donec, ndone;
      vt[0] = '{3, -1, 0, 11, 15};
      vt[1] = '{3,  1, 2, 11, 17};
      vt[2] = '{0, -1, 0, -1,  1};
      vt[3] = '{1, -1, 0,  9, 13};
      vt[4] = '{5,  3, 3, 13, 20};

      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset", act_v, '0);
      rst_n = 1;
      out_ready = 1;
      @(negedge clk);

      for (int v = 0; v < 5; v++) begin
         run_tile(vt[v].k, vt[v].srow, vt[v].slen, 1'b0, first, donec);
         chk_int("first_valid", first, vt[v].exp_first);
         chk_int("done_cycle", donec, vt[v].exp_done);
         repeat (2) tick();
      end

      // reset in the middle of a drain
      start = 1;
      k_len = 8'd3;
      out_ready = 1;
      for (int cyc = 0; cyc < 100 && !(m_act && m_acc == 2); cyc++) begin
         tick();
         start = 0;
      end
      start = 0;
      rst_n = 0;
      #1;
      chk("abort_zero", act_v, '0);
      model_reset();
      @(negedge clk);
      repeat (2) tick();
      rst_n = 1;
      run_tile(1, -1, 0, 1'b0, first, donec);
      chk_int("post_rst_first", first, 9);
      chk_int("post_rst_done", donec, 13);
      repeat (2) tick();

      // start pulsed while busy is ignored
      start = 1;
      k_len = 8'd4;
      ndone = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         out_ready = 1;
         tick();
         start = (cyc == 2);
         k_len = (cyc == 2) ? 8'd7 : 8'd4;
         if (obs_done) ndone++;
      end
      start = 0;
      chk_int("one_done", ndone, 1);

`ifdef SYSTOLIC_TILE_ACCUM_EN
      run_tile(2, -1, 0, 1'b1, first, donec);
      chk_int("keep_first", first, -1);
      chk_int("keep_done", donec, 10);
      tick();
      run_tile(2, -1, 0, 1'b0, first, donec);
      chk_int("acc_first", first, 10);
      chk_int("acc_done", donec, 14);
      repeat (2) tick();
`endif

      // randomized traffic with backpressure and stray starts
      for (int cyc = 0; cyc < 1500; cyc++) begin
         start = ($urandom_range(0, 5) == 0);
         k_len = KW'($urandom_range(0, 9));
         out_ready = ($urandom_range(0, 3) != 0);
         tb_keep = ($urandom_range(0, 2) == 0);
         tick();
      end
      start = 0;
      out_ready = 1;
      for (int cyc = 0; cyc < 200 && m_act; cyc++) tick();
      #1;
      chk_int("final_idle", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
